edge_capture_counter: RTL and testbench
=======================================

// Module: edge_capture_counter
//
// PURPOSE
//   Gated event counter: the input-side counterpart of the free-running output counter.
//   - Synchronises an external pin (sig_in) and counts its rising edges over a fixed window
//     of GATE_CYCLES clocks.
//   - Latches the result and exposes it byte-by-byte on an 8-bit port.
//   - Sits between a dedicated input pin and the dedicated output byte in the top level;
//     used for frequency and event-rate measurement.
//
// PARAMETERS
//   CNT_W        16    result/counter width in bits; must be a multiple of 8, >= 8
//   GATE_CYCLES  1000  measurement window length in clk cycles; >= 1
//   SYNC_STAGES  2     synchroniser flops on sig_in; >= 2
//
// PORTS
//   clk       in   1                    single clock; all logic on rising edge
//   rst       in   1                    synchronous, active-high reset
//   sig_in    in   1                    asynchronous external signal to measure
//   start     in   1                    1-cycle pulse: begin a measurement
//   byte_sel  in   max(1,$clog2(CNT_W/8))  selects result byte shown on byte_out; 0 = LSB
//   busy      out  1                    high while measuring (ARM and GATE states)
//   done      out  1                    1-cycle pulse when a new result is latched
//   overflow  out  1                    last result saturated
//   count     out  CNT_W                last latched result
//   byte_out  out  8                    count[8*byte_sel +: 8]; 0 if byte_sel is out of range
//
// BEHAVIOUR
//   Reset:
//   - rst sampled high: state=IDLE; count, overflow, done, busy, running counter,
//     window counter and all synchroniser/edge flops = 0.
//   - Applies in any state; a measurement in progress is aborted with no done pulse.
//   Edge detection:
//   - sig_in passes through SYNC_STAGES flops, then one previous-value flop.
//   - rise = sync & ~prev.
//   - A sig_in 0->1 transition is registered as rise SYNC_STAGES+1 clocks later.
//   FSM: IDLE -> ARM -> GATE -> HOLD.
//   - IDLE / HOLD, start=1: go to ARM.
//   - ARM (1 cycle): clear the running counter and the sticky overflow flag;
//     load window counter = GATE_CYCLES-1.
//   - GATE: each cycle with rise=1 increments the running counter. The counter saturates
//     at all-ones and sets the sticky overflow flag. Window counter decrements each cycle.
//     Exits after exactly GATE_CYCLES GATE cycles. A rise in the final GATE cycle is counted.
//   - GATE exit: count <= running counter value including that final cycle's rise;
//     overflow <= sticky flag; done=1 for exactly one cycle (first HOLD cycle).
//   - start while in ARM or GATE: ignored.
//   - busy = (state==ARM || state==GATE), registered.
//     Total busy duration = GATE_CYCLES+1 cycles.
//   Output stability:
//   - count and overflow change only at GATE exit or reset.
//   - They hold the previous result throughout a new measurement.
//   - byte_out is a combinational mux of registered count; it updates in the same cycle
//     byte_sel changes.
//
// STRUCTURE
//   Shared package edge_capture_pkg:
//   - state enum {IDLE, ARM, GATE, HOLD}, 2 bits
//   - BYTE_W = 8
//   - function sel_width(CNT_W) for byte_sel sizing
//   Sub-module sync_edge_detect #(SYNC_STAGES):
//   - ports: clk, rst, async_in, rise
//   - the synchroniser chain plus previous-value flop
//   Top body: FSM, window down-counter, saturating running counter, result register,
//   byte mux.
//
// TESTING
//   1. rst held 2 cycles mid-GATE
//      -> next cycle: busy=0, done=0, count=0, overflow=0; no done pulse afterwards.
//   2. GATE_CYCLES=100; sig_in period 10 clk, first rise 1 clk after start
//      -> busy high 101 cycles, single done pulse, count=10, overflow=0.
//   3. sig_in held 1 throughout
//      -> count=0; sig_in held 0 -> count=0; each run gives exactly one done pulse.
//   4. CNT_W=8, GATE_CYCLES=1000, sig_in period 2 clk
//      -> count=8'hFF, overflow=1.
//      Next run with period 10 -> count=100, overflow=0.
//   5. GATE_CYCLES=20000, period 4 clk
//      -> count=16'h1388; byte_sel=0 -> byte_out=8'h88; byte_sel=1 -> byte_out=8'h13.
//   6. start pulsed at GATE cycle 50 of run 2
//      -> ignored: done at the original time, count=10.
//      start in HOLD -> new run begins next cycle.

Source files
------------

// File: rtl/edge_capture_counter_pkg.sv
// Shared types and sizing helpers for the gated edge counter.
package edge_capture_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    HOLD = 2'd3
  } state_e;

  // byte_sel width: enough bits to address every result byte, never less than 1.
  function automatic int sel_width(input int cnt_w);
    int n;
    n = cnt_w / BYTE_W;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_capture_counter_if.sv
// Control/result bus of the edge capture counter.
interface edge_capture_counter_if
  import edge_capture_pkg::*;
#(
  parameter int CNT_W = 16
);

  localparam int SEL_W = sel_width(CNT_W);

  logic                 start;
  logic [SEL_W-1:0]     byte_sel;
  logic                 busy;
  logic                 done;
  logic                 overflow;
  logic [CNT_W-1:0]     count;
  logic [BYTE_W-1:0]    byte_out;

  modport master (
    output start, byte_sel,
    input  busy, done, overflow, count, byte_out
  );

  modport slave (
    input  start, byte_sel,
    output busy, done, overflow, count, byte_out
  );

endinterface

// File: rtl/edge_capture_counter_sync.sv
// Synchroniser chain for an asynchronous pin plus rising-edge detect.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/edge_capture_counter.sv
// Counts synchronised rising edges of sig_in over a GATE_CYCLES window and
// publishes the latched result, byte-addressable.
module edge_capture_counter
  import edge_capture_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int GATE_CYCLES = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sig_in,
  edge_capture_counter_if.slave bus
);

  localparam int NB    = CNT_W / BYTE_W;
  localparam int WIN_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  state_e             state, state_nx;
  logic [WIN_W-1:0]   win_q;
  logic [CNT_W-1:0]   run_q, run_nx;
  logic               sticky_q, sticky_nx;
  logic [CNT_W-1:0]   count_q;
  logic               ovf_q, busy_q, done_q;
  logic               rise;
  logic               gate_end;
  logic [BYTE_W-1:0]  byte_nx;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (sig_in),
    .rise     (rise)
  );

  assign gate_end = (state == GATE) && (win_q == '0);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, HOLD: if (bus.start) state_nx = ARM;
      ARM:        state_nx = GATE;
      GATE:       if (win_q == '0) state_nx = HOLD;
      default:    state_nx = IDLE;
    endcase
  end

  // Next running count folds in this cycle's rise so the final GATE cycle is included.
  always_comb begin
    run_nx    = run_q;
    sticky_nx = sticky_q;
    if (state == ARM) begin
      run_nx    = '0;
      sticky_nx = 1'b0;
    end else if (state == GATE && rise) begin
      if (&run_q) sticky_nx = 1'b1;
      else        run_nx    = run_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      win_q    <= '0;
      run_q    <= '0;
      sticky_q <= 1'b0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      run_q    <= run_nx;
      sticky_q <= sticky_nx;
      busy_q   <= (state_nx == ARM) || (state_nx == GATE);
      done_q   <= gate_end;
      if (state == ARM)
        win_q <= WIN_W'(GATE_CYCLES - 1);
      else if (state == GATE && win_q != '0)
        win_q <= win_q - 1'b1;
      if (gate_end) begin
        count_q <= run_nx;
        ovf_q   <= sticky_nx;
      end
    end
  end

  always_comb begin
    byte_nx = '0;
    for (int i = 0; i < NB; i++)
      if (int'(bus.byte_sel) == i) byte_nx = count_q[i*BYTE_W +: BYTE_W];
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.count    = count_q;
  assign bus.byte_out = byte_nx;

endmodule

// File: tb/tb_edge_capture_counter.sv
// Directed bench: three counter instances (short window, 8-bit saturating, long window).
module tb_edge_capture_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // sig_in generators: period 0 means hold lvl, else square wave phased from base.
  int cyc = 0;
  int per  [3] = '{0, 0, 0};
  int base [3] = '{0, 0, 0};
  logic [2:0] lvl = 3'b000;
  logic [2:0] sig = 3'b000;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++)
      sig[k] = (per[k] == 0) ? lvl[k] : (((cyc - base[k]) % per[k]) < per[k] / 2);
    cyc = cyc + 1;
  end

  logic [2:0] start = 3'b000;
  logic       sel_a = 1'b0, sel_b = 1'b0, sel_c = 1'b0;

  edge_capture_counter_if #(.CNT_W(16)) ifc_a ();
  edge_capture_counter_if #(.CNT_W(8))  ifc_b ();
  edge_capture_counter_if #(.CNT_W(16)) ifc_c ();

  assign ifc_a.start = start[0];
  assign ifc_b.start = start[1];
  assign ifc_c.start = start[2];
  assign ifc_a.byte_sel = sel_a;
  assign ifc_b.byte_sel = sel_b;
  assign ifc_c.byte_sel = sel_c;

  edge_capture_counter #(.CNT_W(16), .GATE_CYCLES(100), .SYNC_STAGES(2)) u_a (
    .clk(clk), .rst(rst), .sig_in(sig[0]), .bus(ifc_a));
  edge_capture_counter #(.CNT_W(8), .GATE_CYCLES(1000), .SYNC_STAGES(2)) u_b (
    .clk(clk), .rst(rst), .sig_in(sig[1]), .bus(ifc_b));
  edge_capture_counter #(.CNT_W(16), .GATE_CYCLES(20000), .SYNC_STAGES(2)) u_c (
    .clk(clk), .rst(rst), .sig_in(sig[2]), .bus(ifc_c));

  logic [2:0] busy, done, ovf;
  logic [2:0][15:0] cnt;
  assign busy = {ifc_c.busy, ifc_b.busy, ifc_a.busy};
  assign done = {ifc_c.done, ifc_b.done, ifc_a.done};
  assign ovf  = {ifc_c.overflow, ifc_b.overflow, ifc_a.overflow};
  assign cnt[0] = ifc_a.count;
  assign cnt[1] = {8'h00, ifc_b.count};
  assign cnt[2] = ifc_c.count;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wave(input int k, input int p, input logic l);
    per[k]  = p;
    lvl[k]  = l;
    base[k] = cyc;
  endtask

  // Pulse start, then observe limit cycles: busy count, done pulses, first done index.
  task automatic measure(input int k, input int limit,
                         output int bcyc, output int dn, output int dat);
    bcyc = 0; dn = 0; dat = -1;
    start[k] = 1'b1;
    step();
    start[k] = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (busy[k]) bcyc++;
      if (done[k]) begin
        dn++;
        if (dat < 0) dat = i;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy[k] !== 1'b0 || done[k] !== 1'b0 || ovf[k] !== 1'b0 || cnt[k] !== 16'h0) begin
        errors++;
        $display("FAIL reset_state[%0d]: busy=%b done=%b ovf=%b count=%h, required all 0",
                 k, busy[k], done[k], ovf[k], cnt[k]);
      end
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int b, d, t;
    start[0] = 1'b1;
    set_wave(0, 10, 1'b0);
    step();
    start[0] = 1'b0;
    b = 0; d = 0; t = -1;
    for (int i = 0; i < 130; i++) begin
      if (busy[0]) b++;
      if (done[0]) begin d++; if (t < 0) t = i; end
      step();
    end
    checks++;
    if (b !== 101) begin errors++; $display("FAIL basic_busy_len: got %0d required 101", b); end
    checks++;
    if (d !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d required 1", d); end
    checks++;
    if (t !== 101) begin errors++; $display("FAIL basic_done_time: got %0d required 101", t); end
    checks++;
    if (cnt[0] !== 16'd10 || ovf[0] !== 1'b0) begin
      errors++; $display("FAIL basic_count: got %0d ovf=%b required 10 ovf=0", cnt[0], ovf[0]);
    end
  endtask

  task automatic test_reset_mid_gate();
    int d;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (50) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || cnt[0] !== 16'h0 || ovf[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_gate_reset: busy=%b done=%b count=%h ovf=%b required all 0",
               busy[0], done[0], cnt[0], ovf[0]);
    end
    d = 0;
    for (int i = 0; i < 150; i++) begin
      if (done[0] || busy[0]) d++;
      step();
    end
    checks++;
    if (d !== 0) begin errors++; $display("FAIL mid_gate_no_done: got %0d active cycles required 0", d); end
  endtask

  task automatic test_levels();
    int b, d, t;
    set_wave(0, 0, 1'b1);
    repeat (10) step();
    measure(0, 120, b, d, t);
    checks++;
    if (cnt[0] !== 16'd0 || d !== 1) begin
      errors++; $display("FAIL level_high: count=%0d done=%0d required count=0 done=1", cnt[0], d);
    end
    set_wave(0, 0, 1'b0);
    repeat (10) step();
    measure(0, 120, b, d, t);
    checks++;
    if (cnt[0] !== 16'd0 || d !== 1) begin
      errors++; $display("FAIL level_low: count=%0d done=%0d required count=0 done=1", cnt[0], d);
    end
  endtask

  task automatic test_start_ignored();
    int d, t;
    set_wave(0, 10, 1'b0);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    d = 0; t = -1;
    for (int i = 0; i < 105; i++) begin
      start[0] = (i == 51);
      if (done[0]) begin d++; if (t < 0) t = i; end
      if (t < 0) step();
      else break;
    end
    start[0] = 1'b0;
    checks++;
    if (t !== 101 || d !== 1) begin
      errors++; $display("FAIL start_ignored_done: at %0d pulses %0d required at 101 pulses 1", t, d);
    end
    checks++;
    if (cnt[0] !== 16'd10) begin errors++; $display("FAIL start_ignored_count: got %0d required 10", cnt[0]); end
    // first HOLD cycle: a start here launches a new run
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL hold_restart: busy=%b required 1", busy[0]); end
    checks++;
    if (cnt[0] !== 16'd10) begin errors++; $display("FAIL hold_keeps_count: got %0d required 10", cnt[0]); end
    repeat (110) step();
  endtask

  task automatic test_saturate();
    int b, d, t;
    set_wave(1, 2, 1'b0);
    repeat (5) step();
    measure(1, 1020, b, d, t);
    checks++;
    if (cnt[1] !== 16'h00FF || ovf[1] !== 1'b1) begin
      errors++; $display("FAIL saturate: count=%h ovf=%b required ff ovf=1", cnt[1], ovf[1]);
    end
    checks++;
    if (b !== 1001 || t !== 1001 || d !== 1) begin
      errors++; $display("FAIL saturate_timing: busy=%0d done_at=%0d pulses=%0d required 1001 1001 1", b, t, d);
    end
    set_wave(1, 10, 1'b0);
    repeat (5) step();
    measure(1, 1020, b, d, t);
    checks++;
    if (cnt[1] !== 16'd100 || ovf[1] !== 1'b0) begin
      errors++; $display("FAIL rerun_after_sat: count=%0d ovf=%b required 100 ovf=0", cnt[1], ovf[1]);
    end
    sel_b = 1'b0;
    #1;
    checks++;
    if (ifc_b.byte_out !== 8'd100) begin errors++; $display("FAIL b_byte0: got %h required 64", ifc_b.byte_out); end
    sel_b = 1'b1;
    #1;
    checks++;
    if (ifc_b.byte_out !== 8'h00) begin errors++; $display("FAIL b_byte_oob: got %h required 00", ifc_b.byte_out); end
  endtask

  task automatic test_bytes();
    int b, d, t;
    set_wave(2, 4, 1'b0);
    repeat (5) step();
    measure(2, 20020, b, d, t);
    checks++;
    if (cnt[2] !== 16'h1388 || ovf[2] !== 1'b0) begin
      errors++; $display("FAIL long_count: got %h ovf=%b required 1388 ovf=0", cnt[2], ovf[2]);
    end
    checks++;
    if (b !== 20001 || d !== 1) begin
      errors++; $display("FAIL long_busy: busy=%0d pulses=%0d required 20001 1", b, d);
    end
    sel_c = 1'b0;
    #1;
    checks++;
    if (ifc_c.byte_out !== 8'h88) begin errors++; $display("FAIL c_byte0: got %h required 88", ifc_c.byte_out); end
    sel_c = 1'b1;
    #1;
    checks++;
    if (ifc_c.byte_out !== 8'h13) begin errors++; $display("FAIL c_byte1: got %h required 13", ifc_c.byte_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_gate();
    test_levels();
    test_start_ignored();
    test_saturate();
    test_bytes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
